hand_bank_datapath: RTL and testbench
=====================================

// Module: hand_bank_datapath
// PURPOSE
// Parametrised card-hand register bank for the baccarat engine.
// - Holds NUM_HANDS hands of up to CARDS_PER_HAND cards each.
// - Loads cards through a deal_req/deal_ack handshake.
// - Auto-advances a per-hand slot counter and computes each hand's baccarat score.
// - Sits between the card dealer and the game FSM; generalises the fixed two-hand, three-card datapath.
// PARAMETERS
// NUM_HANDS       2  number of hands (>=1); hand 0 = player, hand 1 = banker
// CARDS_PER_HAND  3  card slots per hand (>=2)
// HS_W            max(1,$clog2(NUM_HANDS))  width of the hand select (localparam)
// CNT_W           $clog2(CARDS_PER_HAND+1)  width of the per-hand count (localparam)
// PORTS
// clk          in   1                   clock, all state on posedge
// resetb       in   1                   reset, synchronous, active-low
// deal_req     in   1                   request to load deal_card into hand deal_hand
// deal_hand    in   HS_W                target hand index
// deal_card    in   4                   card code: 0 = empty, 1 = A .. 13 = K
// clear_all    in   1                   synchronous clear of all hands and of err
// deal_ack     out  1                   one-cycle pulse, the cycle after a sampled deal_req
// deal_ok      out  1                   valid with deal_ack: 1 = card stored, 0 = rejected
// cards_out    out  NUM_HANDS*CARDS_PER_HAND*4  card of hand h, slot s at [(h*CARDS_PER_HAND+s)*4 +: 4]
// count_out    out  NUM_HANDS*CNT_W     cards held per hand
// score_out    out  NUM_HANDS*4         baccarat score per hand, 0..9
// full_out     out  NUM_HANDS           count == CARDS_PER_HAND
// natural_out  out  NUM_HANDS           count == 2 and score is 8 or 9
// err          out  1                   sticky error flag
// BEHAVIOUR
// Reset (resetb = 0 at posedge):
// - All card slots, counts, deal_ack, deal_ok and err go to 0.
// - Reset overrides every other input.
// Deal:
// - deal_req = 1 at edge N stores deal_card in slot count[deal_hand] of that hand.
// - The same edge increments count[deal_hand].
// - deal_ack = 1 and deal_ok = 1 during cycle N+1 (registered).
// - deal_req held high issues one deal per cycle; there are no wait states.
// Rejection (deal_ok = 0, deal_ack still pulses, no state change except err = 1):
// - Target hand is full.
// - deal_hand >= NUM_HANDS.
// - deal_card == 0 or deal_card > 13.
// clear_all = 1 at edge N:
// - Zeros all slots, counts and err.
// - Wins over a simultaneous deal_req; that deal gets deal_ack = 1, deal_ok = 0, and err stays 0.
// Score:
// - Card value = card when card <= 9, else 0 (empty, 10, J, Q and K all score 0).
// - score = (sum of values over the hand's slots) mod 10.
// - Compute the sum in ceil(log2(9*CARDS_PER_HAND+1)) bits, with no truncation before the mod.
// - score_out, full_out and natural_out are combinational from registered state.
// - They are valid in the cycle after the loading edge, together with deal_ack.
// deal_ack:
// - Low in every cycle not preceded by a sampled deal_req.
// - A deal in the last cycle before reset does not produce deal_ack after reset.
// TESTING
// 1. Reset:
//    - Stimulus: hold resetb = 0 for 2 cycles with deal_req = 1.
//    - Required: all outputs 0; no deal_ack.
// 2. Basic deal and score:
//    - Stimulus: deal hand0 7, hand0 9, hand1 13, hand1 8.
//    - Required: score_out = {8, 6}; natural_out = 2'b10; four deal_ack/deal_ok pulses.
// 3. Full hand:
//    - Stimulus: deal hand0 cards 4, 5, 6, then a fourth card 2.
//    - Required: fourth deal gives deal_ok = 0 and err = 1; cards unchanged; score = 5; full_out[0] = 1.
// 4. Illegal input:
//    - Stimulus: deal_card = 14, then deal_hand = NUM_HANDS (run with NUM_HANDS = 3).
//    - Required: both rejected; err stays 1 until clear_all.
// 5. Clear priority:
//    - Stimulus: clear_all and deal_req in the same cycle.
//    - Required: all counts 0; deal_ok = 0; err = 0.
// 6. Parameter sweep:
//    - Stimulus: NUM_HANDS = 4, CARDS_PER_HAND = 5; deal 9 five times to hand 3.
//    - Required: score_out[15:12] = 5; count = 5; full_out = 4'b1000.

Source files
------------

// File: rtl/hand_bank_datapath.sv
// Card-hand register bank for the baccarat engine: loads cards through a
// deal_req/deal_ack handshake and scores every hand from its stored cards.
module hand_bank_datapath #(
    parameter int NUM_HANDS      = 2,
    parameter int CARDS_PER_HAND = 3,
    localparam int HS_W  = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
    localparam int CNT_W = $clog2(CARDS_PER_HAND + 1)
) (
    input  logic                                clk,
    input  logic                                resetb,
    input  logic                                deal_req,
    input  logic [HS_W-1:0]                     deal_hand,
    input  logic [3:0]                          deal_card,
    input  logic                                clear_all,
    output logic                                deal_ack,
    output logic                                deal_ok,
    output logic [NUM_HANDS*CARDS_PER_HAND*4-1:0] cards_out,
    output logic [NUM_HANDS*CNT_W-1:0]          count_out,
    output logic [NUM_HANDS*4-1:0]              score_out,
    output logic [NUM_HANDS-1:0]                full_out,
    output logic [NUM_HANDS-1:0]                natural_out,
    output logic                                err
);
    localparam int SUM_W = $clog2(9 * CARDS_PER_HAND + 1);

    logic [3:0]       r_cards [NUM_HANDS][CARDS_PER_HAND];
    logic [CNT_W-1:0] r_count [NUM_HANDS];
    logic             r_ack;
    logic             r_ok;
    logic             r_err;

    logic [CNT_W-1:0] w_sel_count;
    logic             w_hand_ok;
    logic             w_card_ok;
    logic             w_accept;
    logic [SUM_W-1:0] w_sum   [NUM_HANDS];
    logic [3:0]       w_score [NUM_HANDS];

    // Look up the targeted hand without ever indexing past the last hand.
    always_comb begin
        w_sel_count = {CNT_W{1'b0}};
        w_hand_ok   = 1'b0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            w_hand_ok   = w_hand_ok | (deal_hand == HS_W'(h));
            w_sel_count = (deal_hand == HS_W'(h)) ? r_count[h] : w_sel_count;
        end
        w_card_ok = (deal_card != 4'd0) && (deal_card <= 4'd13);
        w_accept  = w_hand_ok && w_card_ok && (w_sel_count != CNT_W'(CARDS_PER_HAND));
    end

    // Card storage, slot counters and handshake; clear_all beats a same-cycle deal.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            for (int h = 0; h < NUM_HANDS; h++) begin
                r_count[h] <= {CNT_W{1'b0}};
                for (int s = 0; s < CARDS_PER_HAND; s++) begin
                    r_cards[h][s] <= 4'd0;
                end
            end
            r_ack <= 1'b0;
            r_ok  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= deal_req;
            r_ok  <= 1'b0;
            if (clear_all) begin
                for (int h = 0; h < NUM_HANDS; h++) begin
                    r_count[h] <= {CNT_W{1'b0}};
                    for (int s = 0; s < CARDS_PER_HAND; s++) begin
                        r_cards[h][s] <= 4'd0;
                    end
                end
                r_err <= 1'b0;
            end else if (deal_req) begin
                if (w_accept) begin
                    for (int h = 0; h < NUM_HANDS; h++) begin
                        if (deal_hand == HS_W'(h)) begin
                            r_count[h] <= r_count[h] + CNT_W'(1);
                        end
                        for (int s = 0; s < CARDS_PER_HAND; s++) begin
                            if ((deal_hand == HS_W'(h)) && (w_sel_count == CNT_W'(s))) begin
                                r_cards[h][s] <= deal_card;
                            end
                        end
                    end
                    r_ok <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Score: face cards and tens count zero; the full-width sum is reduced mod 10.
    always_comb begin
        for (int h = 0; h < NUM_HANDS; h++) begin
            w_sum[h] = {SUM_W{1'b0}};
            for (int s = 0; s < CARDS_PER_HAND; s++) begin
                w_sum[h] = w_sum[h] + ((r_cards[h][s] <= 4'd9) ? SUM_W'(r_cards[h][s]) : {SUM_W{1'b0}});
            end
            w_score[h] = 4'(w_sum[h] % SUM_W'(10));
        end
    end

    // Flatten per-hand state onto the packed output buses.
    always_comb begin
        cards_out   = {(NUM_HANDS*CARDS_PER_HAND*4){1'b0}};
        count_out   = {(NUM_HANDS*CNT_W){1'b0}};
        score_out   = {(NUM_HANDS*4){1'b0}};
        full_out    = {NUM_HANDS{1'b0}};
        natural_out = {NUM_HANDS{1'b0}};
        for (int h = 0; h < NUM_HANDS; h++) begin
            for (int s = 0; s < CARDS_PER_HAND; s++) begin
                cards_out[(h*CARDS_PER_HAND+s)*4 +: 4] = r_cards[h][s];
            end
            count_out[h*CNT_W +: CNT_W] = r_count[h];
            score_out[h*4 +: 4]         = w_score[h];
            full_out[h]    = (r_count[h] == CNT_W'(CARDS_PER_HAND));
            natural_out[h] = (r_count[h] == CNT_W'(2)) && (w_score[h] >= 4'd8);
        end
    end

    assign deal_ack = r_ack;
    assign deal_ok  = r_ok;
    assign err      = r_err;

endmodule

// File: tb/tb_hand_bank_datapath.sv
// Bench for hand_bank_datapath: a 3-hand/3-card bank against a card-list model,
// plus a 4-hand/5-card instance for the parameter sweep.
module tb_hand_bank_datapath;
    logic clk = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;

    logic        req3 = 1'b0, clr3 = 1'b0;
    logic [1:0]  hand3 = 2'd0;
    logic [3:0]  card3 = 4'd0;
    logic        ack3, ok3, err3;
    logic [35:0] cards3;
    logic [5:0]  count3;
    logic [11:0] score3;
    logic [2:0]  full3, nat3;

    logic        req4 = 1'b0, clr4 = 1'b0;
    logic [1:0]  hand4 = 2'd0;
    logic [3:0]  card4 = 4'd0;
    logic        ack4, ok4, err4;
    logic [79:0] cards4;
    logic [11:0] count4;
    logic [15:0] score4;
    logic [3:0]  full4, nat4;

    hand_bank_datapath #(.NUM_HANDS(3), .CARDS_PER_HAND(3)) u3 (
        .clk(clk), .resetb(resetb), .deal_req(req3), .deal_hand(hand3),
        .deal_card(card3), .clear_all(clr3), .deal_ack(ack3), .deal_ok(ok3),
        .cards_out(cards3), .count_out(count3), .score_out(score3),
        .full_out(full3), .natural_out(nat3), .err(err3));

    hand_bank_datapath #(.NUM_HANDS(4), .CARDS_PER_HAND(5)) u4 (
        .clk(clk), .resetb(resetb), .deal_req(req4), .deal_hand(hand4),
        .deal_card(card4), .clear_all(clr4), .deal_ack(ack4), .deal_ok(ok4),
        .cards_out(cards4), .count_out(count4), .score_out(score4),
        .full_out(full4), .natural_out(nat4), .err(err4));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each hand is a list of dealt cards.
    int mcard [3][3];
    int mcnt  [3];
    bit m_err, e_ack, e_ok;

    typedef struct {
        bit req; int hand; int card; bit clr;
        bit e_ack; bit e_ok; bit e_err; int c_hand; int e_cnt; int e_score;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int exp_score(input int h);
        int sum = 0;
        for (int s = 0; s < mcnt[h]; s++) sum += (mcard[h][s] <= 9) ? mcard[h][s] : 0;
        return sum % 10;
    endfunction

    task automatic model_step(input bit rb, input bit rq, input int hd, input int cd, input bit cl);
        if (!rb) begin
            for (int h = 0; h < 3; h++) mcnt[h] = 0;
            m_err = 0; e_ack = 0; e_ok = 0;
        end else begin
            e_ack = rq; e_ok = 0;
            if (cl) begin
                for (int h = 0; h < 3; h++) mcnt[h] = 0;
                m_err = 0;
            end else if (rq) begin
                if (hd < 3 && cd >= 1 && cd <= 13 && mcnt[hd] < 3) begin
                    mcard[hd][mcnt[hd]] = cd;
                    mcnt[hd]++;
                    e_ok = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic check3(input string nm);
        logic [35:0] ecards = '0;
        logic [5:0]  ecnt = '0;
        logic [11:0] esc = '0;
        logic [2:0]  ef = '0, en = '0;
        for (int h = 0; h < 3; h++) begin
            for (int s = 0; s < mcnt[h]; s++) ecards[(h*3+s)*4 +: 4] = 4'(mcard[h][s]);
            ecnt[h*2 +: 2] = 2'(mcnt[h]);
            esc[h*4 +: 4]  = 4'(exp_score(h));
            ef[h] = (mcnt[h] == 3);
            en[h] = (mcnt[h] == 2) && (exp_score(h) >= 8);
        end
        chk({nm, ".ack"}, 128'(ack3), 128'(e_ack));
        chk({nm, ".ok"}, 128'(ok3), 128'(e_ok));
        chk({nm, ".err"}, 128'(err3), 128'(m_err));
        chk({nm, ".cards"}, 128'(cards3), 128'(ecards));
        chk({nm, ".count"}, 128'(count3), 128'(ecnt));
        chk({nm, ".score"}, 128'(score3), 128'(esc));
        chk({nm, ".full"}, 128'(full3), 128'(ef));
        chk({nm, ".natural"}, 128'(nat3), 128'(en));
    endtask

    task automatic cyc3(input bit rb, input bit rq, input int hd, input int cd, input bit cl);
        resetb = rb; req3 = rq; hand3 = 2'(hd); card3 = 4'(cd); clr3 = cl;
        @(posedge clk);
        model_step(rb, rq, hd, cd, cl);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1, 0, 7,  0, 1, 1, 0, 0, 1, 7};
        tbl[1]  = '{1, 0, 9,  0, 1, 1, 0, 0, 2, 6};
        tbl[2]  = '{1, 1, 13, 0, 1, 1, 0, 1, 1, 0};
        tbl[3]  = '{1, 1, 8,  0, 1, 1, 0, 1, 2, 8};
        tbl[4]  = '{1, 2, 4,  0, 1, 1, 0, 2, 1, 4};
        tbl[5]  = '{1, 2, 5,  0, 1, 1, 0, 2, 2, 9};
        tbl[6]  = '{1, 2, 6,  0, 1, 1, 0, 2, 3, 5};
        tbl[7]  = '{1, 2, 2,  0, 1, 0, 1, 2, 3, 5};
        tbl[8]  = '{1, 0, 14, 0, 1, 0, 1, 0, 2, 6};
        tbl[9]  = '{1, 3, 5,  0, 1, 0, 1, 0, 2, 6};
        tbl[10] = '{1, 0, 5,  1, 1, 0, 0, 0, 0, 0};
        tbl[11] = '{1, 1, 0,  0, 1, 0, 1, 1, 0, 0};
        tbl[12] = '{0, 0, 0,  1, 0, 0, 0, 1, 0, 0};

        // Reset held two cycles with a pending deal.
        cyc3(0, 1, 0, 5, 0);
        check3("reset1");
        cyc3(0, 1, 0, 5, 0);
        check3("reset2");
        cyc3(1, 0, 0, 0, 0);
        chk("reset.no_ack", 128'(ack3), 128'(0));

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            cyc3(1, tbl[i].req, tbl[i].hand, tbl[i].card, tbl[i].clr);
            chk($sformatf("tbl%0d.ack", i), 128'(ack3), 128'(tbl[i].e_ack));
            chk($sformatf("tbl%0d.ok", i), 128'(ok3), 128'(tbl[i].e_ok));
            chk($sformatf("tbl%0d.err", i), 128'(err3), 128'(tbl[i].e_err));
            chk($sformatf("tbl%0d.count", i), 128'(count3[tbl[i].c_hand*2 +: 2]), 128'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.score", i), 128'(score3[tbl[i].c_hand*4 +: 4]), 128'(tbl[i].e_score));
            if (i == 3) begin
                chk("basic.score_pair", 128'(score3[7:0]), 128'(8'h86));
                chk("basic.natural", 128'(nat3), 128'(3'b010));
            end
            if (i == 7) begin
                chk("full.flags", 128'(full3), 128'(3'b100));
                chk("full.cards", 128'(cards3[35:24]), 128'(12'h654));
            end
            check3($sformatf("tbl%0d.model", i));
        end

        // Deal accepted, then reset on the next edge: no ack may appear after reset.
        cyc3(1, 1, 0, 3, 0);
        check3("prerst.deal");
        cyc3(0, 1, 0, 3, 0);
        check3("prerst.reset");
        chk("prerst.no_ack", 128'(ack3), 128'(0));

        // Back-to-back deals with req held high.
        cyc3(1, 1, 1, 9, 0);
        check3("b2b0");
        cyc3(1, 1, 1, 10, 0);
        check3("b2b1");
        cyc3(1, 1, 1, 1, 0);
        check3("b2b2");

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc3($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                 $urandom_range(0, 15) == 0);
            check3($sformatf("rnd%0d", i));
        end
        req3 = 1'b0; clr3 = 1'b0;

        // Parameter sweep: 4 hands x 5 cards, fill hand 3 with nines.
        resetb = 1'b0;
        @(posedge clk); #1;
        resetb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req4 = 1'b1; hand4 = 2'd3; card4 = 4'd9;
            @(posedge clk); #1;
            chk($sformatf("sweep.ack%0d", i), 128'(ack4), 128'(1));
            chk($sformatf("sweep.ok%0d", i), 128'(ok4), 128'(1));
        end
        chk("sweep.score", 128'(score4[15:12]), 128'(5));
        chk("sweep.count", 128'(count4[11:9]), 128'(5));
        chk("sweep.full", 128'(full4), 128'(4'b1000));
        chk("sweep.err0", 128'(err4), 128'(0));
        @(posedge clk); #1;
        req4 = 1'b0;
        chk("sweep.over_ok", 128'(ok4), 128'(0));
        chk("sweep.over_err", 128'(err4), 128'(1));
        chk("sweep.over_cards", 128'(cards4[79:60]), 128'(20'h99999));
        @(posedge clk); #1;
        chk("sweep.ack_drop", 128'(ack4), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
